// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Purpose  : Shared constants and helpers for the single-clock FIFO.
//            - DEFAULT_DSIZE / DEFAULT_ASIZE : default data and address widths
//            - thresholds_ok()               : legality check for the
//                                              almost-full/almost-empty levels
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEFAULT_DSIZE = 8;
  localparam int DEFAULT_ASIZE = 4;

  // Almost-full must lie in 1..DEPTH, almost-empty in 0..DEPTH-1.
  function automatic bit thresholds_ok(input int af_level,
                                       input int ae_level,
                                       input int depth);
    return (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level < depth);
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ram
// Purpose  : DSIZE x 2**ASIZE simple dual-port RAM, one write port and one
//            synchronous read port, both on clk. Only the read register is
//            reset; the array itself keeps its contents.
// Ports    : clk   in  clock
//            rst   in  synchronous active-high reset (read register only)
//            we    in  write enable
//            waddr in  write address [ASIZE-1:0]
//            wdata in  write data    [DSIZE-1:0]
//            re    in  read enable (read register loads only when set)
//            raddr in  read address  [ASIZE-1:0]
//            rdata out registered read data [DSIZE-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read-before-write on an address collision: the old word is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : sync_fifo_ram
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock parametrised FIFO with exact fill level,
//            programmable almost-full/almost-empty thresholds and sticky
//            overflow/underflow flags. Optional first-word-fall-through
//            read mode selected by the macro SYNC_FIFO_FWFT_EN.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            winc, wdata              write request / data
//            wfull, walmost_full      full, level >= AF_LEVEL
//            rinc, rdata              read request / data
//            rempty, ralmost_empty    empty, level <= AE_LEVEL
//            level                    words held (0..DEPTH)
//            overflow, underflow      sticky error flags, cleared by rst
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE    = DEFAULT_DSIZE,
  parameter int ASIZE    = DEFAULT_ASIZE,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH     = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_LVL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_LVL    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_LVL    = (ASIZE+1)'(AE_LEVEL);

  if (!thresholds_ok(AF_LEVEL, AE_LEVEL, DEPTH)) begin : g_bad_thresholds
    $error("sync_fifo: illegal thresholds AF_LEVEL=%0d AE_LEVEL=%0d DEPTH=%0d",
           AF_LEVEL, AE_LEVEL, DEPTH);
  end

  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ASIZE:0]   level_q, level_d;
  logic             wfull_q, wfull_d, rempty_q, rempty_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             push, pop, ram_has_data;
  logic             ram_we, ram_re, rd_adv;
  logic [ASIZE-1:0] ram_raddr;
  logic [DSIZE-1:0] ram_rdata;

  // Level and flags: every flag is computed from the next level so it is
  // exact immediately after the edge.
  always_comb begin
    push         = winc & ~wfull_q;
    pop          = rinc & ~rempty_q;
    ram_has_data = (wptr_q != rptr_q);
    level_d      = level_q + (ASIZE+1)'(push) - (ASIZE+1)'(pop);
    wfull_d      = (level_d == DEPTH_LVL);
    rempty_d     = (level_d == '0);
    afull_d      = (level_d >= AF_LVL);
    aempty_d     = (level_d <= AE_LVL);
    overflow_d   = overflow_q  | (winc & wfull_q);
    underflow_d  = underflow_q | (rinc & rempty_q);
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The output register holds the head word; the RAM holds everything
  // behind it. The RAM is read every cycle at the next read pointer so its
  // output always presents the word that follows the head. A write landing
  // on that same address in the same cycle is captured in a bypass register
  // because the RAM returns the old contents on a collision.
  logic [DSIZE-1:0] out_q, out_d, byp_data_q, byp_data_d, head;
  logic             byp_q, byp_d;

  always_comb begin
    head      = byp_q ? byp_data_q : ram_rdata;
    // A push goes straight to the output register when the FIFO is empty,
    // or when the head is consumed and nothing waits in the RAM.
    ram_we    = push & (level_q != '0) & ~(pop & ~ram_has_data);
    rd_adv    = pop & ram_has_data;
    wptr_d    = wptr_q + (ASIZE+1)'(ram_we);
    rptr_d    = rptr_q + (ASIZE+1)'(rd_adv);
    ram_raddr = rptr_d[ASIZE-1:0];
    ram_re    = 1'b1;
    byp_d     = ram_we & (wptr_q[ASIZE-1:0] == ram_raddr);
    byp_data_d = wdata;
    out_d     = out_q;
    if (rd_adv) begin
      out_d = head;
    end else if (push & ~ram_we) begin
      out_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      out_q      <= out_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign rdata = out_q;
`else
  // Standard mode: the RAM read register is the data output and loads
  // only on a pop.
  always_comb begin
    ram_we    = push;
    rd_adv    = pop & ram_has_data;
    wptr_d    = wptr_q + (ASIZE+1)'(ram_we);
    rptr_d    = rptr_q + (ASIZE+1)'(rd_adv);
    ram_raddr = rptr_q[ASIZE-1:0];
    ram_re    = rd_adv;
  end

  assign rdata = ram_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= (AF_LEVEL == 0);
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign wfull         = wfull_q;
  assign walmost_full  = afull_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = aempty_q;
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Directed self-checking bench for sync_fifo (DEPTH=16, AF=14,
//            AE=2). Expected values are hand-computed; read-data timing
//            follows SYNC_FIFO_FWFT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, winc, rinc;
  logic [7:0] wdata, rdata;
  logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [4:0] level;

  int compared   = 0;
  int mismatched = 0;

  sync_fifo #(
    .DSIZE    (8),
    .ASIZE    (4),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given requests. The read data check is taken where
  // the popped word is visible: before the edge in FWFT, after it otherwise.
  task automatic cycle_rw(input logic w, input logic [7:0] wd, input logic r,
                          input logic chk, input logic [7:0] exp,
                          input string tag);
    winc  = w;
    wdata = wd;
    rinc  = r;
`ifdef SYNC_FIFO_FWFT_EN
    if (chk) check(tag, rdata, exp);
`endif
    step();
    winc = 1'b0;
    rinc = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    if (chk) check(tag, rdata, exp);
`endif
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    step(); step();
    rst = 1'b0;

    // Reset values
    check("rst_level", level, 0);
    check("rst_rempty", rempty, 1);
    check("rst_wfull", wfull, 0);
    check("rst_afull", walmost_full, 0);
    check("rst_aempty", ralmost_empty, 1);
    check("rst_rdata", rdata, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);

    // Reset mid-traffic, with underflow set and words held
    cycle_rw(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "");
    check("pre_unf", underflow, 1);
    for (int i = 0; i < 3; i++) cycle_rw(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 8'h00, "");
    check("pre_level", level, 3);
    rst = 1'b1; winc = 1'b1; wdata = 8'h99;
    step(); step();
    rst = 1'b0; winc = 1'b0;
    check("mid_level", level, 0);
    check("mid_rempty", rempty, 1);
    check("mid_wfull", wfull, 0);
    check("mid_aempty", ralmost_empty, 1);
    check("mid_ovf", overflow, 0);
    check("mid_unf", underflow, 0);

    // Fill 0x00..0x0F
    for (int i = 1; i <= 16; i++) begin
      cycle_rw(1'b1, 8'(i - 1), 1'b0, 1'b0, 8'h00, "");
      check($sformatf("fill_level_%0d", i), level, i);
      check($sformatf("fill_afull_%0d", i), walmost_full, (i >= 14));
      check($sformatf("fill_wfull_%0d", i), wfull, (i == 16));
      check($sformatf("fill_aempty_%0d", i), ralmost_empty, (i <= 2));
      check($sformatf("fill_rempty_%0d", i), rempty, 0);
    end

    // 17th word while full is dropped
    cycle_rw(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, "");
    check("ovf_flag", overflow, 1);
    check("ovf_level", level, 16);
    check("ovf_wfull", wfull, 1);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      cycle_rw(1'b0, 8'h00, 1'b1, 1'b1, 8'(i), $sformatf("drain_data_%0d", i));
      check($sformatf("drain_level_%0d", i), level, 15 - i);
      check($sformatf("drain_rempty_%0d", i), rempty, (i == 15));
      check($sformatf("drain_afull_%0d", i), walmost_full, ((15 - i) >= 14));
    end

    // Read while empty
    cycle_rw(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "");
    check("unf_flag", underflow, 1);
    check("unf_level", level, 0);
    check("unf_ovf_sticky", overflow, 1);

    // Concurrent push+pop at level 5 for 40 cycles
    for (int i = 0; i < 5; i++) cycle_rw(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 8'h00, "");
    for (int i = 0; i < 40; i++) begin
      cycle_rw(1'b1, 8'h25 + 8'(i), 1'b1, 1'b1, 8'h20 + 8'(i),
               $sformatf("conc_data_%0d", i));
      check($sformatf("conc_level_%0d", i), level, 5);
    end
    for (int i = 0; i < 5; i++)
      cycle_rw(1'b0, 8'h00, 1'b1, 1'b1, 8'h48 + 8'(i), $sformatf("conc_tail_%0d", i));
    check("conc_empty", rempty, 1);

    // Full plus both requests: only the pop happens
    for (int i = 0; i < 16; i++) cycle_rw(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 8'h00, "");
    check("full_b4_both", wfull, 1);
    cycle_rw(1'b1, 8'hFF, 1'b1, 1'b1, 8'h60, "full_both_data");
    check("full_both_level", level, 15);
    check("full_both_wfull", wfull, 0);
    for (int i = 1; i < 16; i++)
      cycle_rw(1'b0, 8'h00, 1'b1, 1'b1, 8'h60 + 8'(i), $sformatf("full_tail_%0d", i));
    check("full_tail_level", level, 0);

    // Empty plus both requests: only the push happens
    cycle_rw(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, "");
    check("empty_both_level", level, 1);
    check("empty_both_rempty", rempty, 0);

    // Push+pop at level 1
    cycle_rw(1'b1, 8'h78, 1'b1, 1'b1, 8'h77, "lvl1_both_data");
    check("lvl1_both_level", level, 1);
    check("lvl1_both_rempty", rempty, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("lvl1_both_head", rdata, 8'h78);
`endif
    cycle_rw(1'b0, 8'h00, 1'b1, 1'b1, 8'h78, "lvl1_pop_data");
    check("lvl1_pop_rempty", rempty, 1);

    // Single push into empty: read-data timing
    cycle_rw(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, "");
    check("a5_rempty", rempty, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("a5_fwft_data", rdata, 8'hA5);
`else
    step();
    check("a5_std_hold", rdata, 8'h78);
`endif
    cycle_rw(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, "a5_pop_data");
    check("a5_pop_rempty", rempty, 1);
    check("a5_pop_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire
